// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light monitor: lamp encodings, direction
// and FSM state enums, and the fixed N->S->E->W rotation order.
package tlc_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_e;

  // Direction that must go green after d finishes; W wraps back to N.
  function automatic dir_e next_dir(input dir_e d);
    return dir_e'(d + 2'd1);
  endfunction

  function automatic logic is_lamp(input logic [2:0] v);
    return (v == LAMP_RED) || (v == LAMP_YEL) || (v == LAMP_GRN);
  endfunction

endpackage

// File: rtl/tlc_dwell_cnt.sv
// Saturating dwell counter for the monitor FSM.
//   clk, rst_a  : clock, asynchronous active-low reset (count -> 0)
//   restart_i   : load 1 (first cycle of a newly entered state)
//   limit_i     : dwell limit of the current state
//   at_limit_o  : count == limit
//   below_o     : count <  limit
module tlc_dwell_cnt #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             at_limit_o,
  output logic             below_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      count_q <= '0;
    end else if (restart_i) begin
      count_q <= CNT_W'(1);
    end else if (count_q != '1) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign at_limit_o = (count_q == limit_i);
  assign below_o    = (count_q <  limit_i);

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor. Observes four lamp buses and checks
// encoding, mutual exclusion, per-bus step legality, N->S->E->W order and
// green/yellow dwell times. All outputs are registered: one cycle latency.
//   clk, rst_a            : clock, asynchronous active-low reset
//   n/s/e/w_lights        : lamp buses (100 red, 010 yellow, 001 green)
//   clr                   : synchronous clear of err_sticky
//   phase, phase_valid    : lit direction and whether exactly one is legally lit
//   err_conflict/encoding/transition/timing : single-cycle error pulses
//   err_sticky            : latched pulses {timing, transition, encoding, conflict}
//   rotations             : count of clean full rotations (wraps)
module traffic_light_monitor
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] n_lights,
  input  logic [2:0] s_lights,
  input  logic [2:0] e_lights,
  input  logic [2:0] w_lights,
  input  logic       clr,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       err_conflict,
  output logic       err_encoding,
  output logic       err_transition,
  output logic       err_timing,
  output logic [3:0] err_sticky,
  output logic [7:0] rotations
);

  localparam logic [CNT_W-1:0] G_LIM = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(YELLOW_CYC);

  state_e      state_q, state_d;
  dir_e        exp_q, exp_d;
  logic        untimed_q, untimed_d;
  logic        rot_ok_q, rot_ok_d;
  logic [1:0]  phase_q, phase_d;
  logic        valid_q, valid_d;
  logic [3:0]  pulse_q, pulse_d;
  logic [3:0]  sticky_q, sticky_d;
  logic [7:0]  rot_q, rot_d;

  logic [2:0]  bus [4];
  logic [2:0]  lit_cnt;
  logic        enc_bad, conflict, all_red;
  dir_e        lit_dir;
  logic [2:0]  lit_val, act_val;
  logic        e_trans, e_time, rot_evt, n_start;
  logic        at_lim, below;
  logic [CNT_W-1:0] limit;

  always_comb begin : decode
    bus[0]  = n_lights;
    bus[1]  = s_lights;
    bus[2]  = e_lights;
    bus[3]  = w_lights;
    lit_cnt = '0;
    enc_bad = 1'b0;
    lit_dir = DIR_N;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!is_lamp(bus[i])) enc_bad = 1'b1;
      if (bus[i] != LAMP_RED) begin
        lit_cnt = lit_cnt + 3'd1;
        lit_dir = dir_e'(i[1:0]);
      end
    end
  end

  assign conflict = (lit_cnt > 3'd1);
  assign all_red  = (lit_cnt == 3'd0);
  assign lit_val  = bus[lit_dir];
  assign act_val  = bus[exp_q];
  assign limit    = (state_q == ST_YELLOW) ? Y_LIM : G_LIM;

  tlc_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .clk        (clk),
    .rst_a      (rst_a),
    .restart_i  (state_d != state_q),
    .limit_i    (limit),
    .at_limit_o (at_lim),
    .below_o    (below)
  );

  // untimed_q marks a green phase picked up mid-way after an error: its start
  // was not observed, so its dwell is not checked (avoids a second error for
  // the same event). Cleared once all-red or a fresh yellow is seen.
  always_comb begin : next_state
    state_d   = state_q;
    exp_d     = exp_q;
    untimed_d = untimed_q;
    e_trans   = 1'b0;
    e_time    = 1'b0;
    rot_evt   = 1'b0;
    n_start   = 1'b0;
    if (conflict || enc_bad) begin
      state_d   = ST_IDLE;
      untimed_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (all_red) begin
            untimed_d = 1'b0;
          end else if (lit_val == LAMP_GRN) begin
            state_d = ST_GREEN;
            exp_d   = lit_dir;
            n_start = (lit_dir == DIR_N) && !untimed_q;
          end
        end
        ST_GREEN: begin
          if (act_val == LAMP_GRN) begin
            e_time = !untimed_q && at_lim;
          end else if (act_val == LAMP_YEL) begin
            state_d   = ST_YELLOW;
            untimed_d = 1'b0;
            e_time    = !untimed_q && below;
          end else begin
            e_trans   = 1'b1;
            state_d   = ST_IDLE;
            untimed_d = 1'b1;
          end
        end
        ST_YELLOW: begin
          if (act_val == LAMP_YEL) begin
            e_time = at_lim;
          end else if (all_red) begin
            state_d = ST_ALLRED;
            e_time  = below;
            rot_evt = (exp_q == DIR_W);
          end else begin
            e_trans   = 1'b1;
            state_d   = ST_IDLE;
            untimed_d = 1'b1;
          end
        end
        ST_ALLRED: begin
          if (!all_red) begin
            if (lit_val == LAMP_GRN && lit_dir == next_dir(exp_q)) begin
              state_d = ST_GREEN;
              exp_d   = lit_dir;
              n_start = (lit_dir == DIR_N);
            end else begin
              e_trans   = 1'b1;
              state_d   = ST_IDLE;
              untimed_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin : outputs
    phase_d = phase_q;
    valid_d = 1'b0;
    if (lit_cnt == 3'd1 && !enc_bad) begin
      valid_d = 1'b1;
      phase_d = lit_dir;
    end
    pulse_d  = {e_time, e_trans, enc_bad, conflict};
    sticky_d = (clr ? 4'b0000 : sticky_q) | pulse_d;
    rot_ok_d = rot_ok_q;
    if (|pulse_d)     rot_ok_d = 1'b0;
    else if (n_start) rot_ok_d = 1'b1;
    rot_d = rot_q;
    if (rot_evt && rot_ok_q && !e_time) rot_d = rot_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_a) begin : regs
    if (!rst_a) begin
      state_q   <= ST_IDLE;
      exp_q     <= DIR_N;
      untimed_q <= 1'b0;
      rot_ok_q  <= 1'b0;
      phase_q   <= '0;
      valid_q   <= 1'b0;
      pulse_q   <= '0;
      sticky_q  <= '0;
      rot_q     <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      untimed_q <= untimed_d;
      rot_ok_q  <= rot_ok_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      pulse_q   <= pulse_d;
      sticky_q  <= sticky_d;
      rot_q     <= rot_d;
    end
  end

  assign phase          = phase_q;
  assign phase_valid    = valid_q;
  assign err_conflict   = pulse_q[0];
  assign err_encoding   = pulse_q[1];
  assign err_transition = pulse_q[2];
  assign err_timing     = pulse_q[3];
  assign err_sticky     = sticky_q;
  assign rotations      = rot_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam logic [2:0]  R = 3'b100;
  localparam logic [2:0]  Y = 3'b010;
  localparam logic [2:0]  G = 3'b001;
  localparam logic [11:0] ALLRED = {R, R, R, R};

  logic       clk = 1'b0;
  logic       rst_a;
  logic [2:0] n_l, s_l, e_l, w_l;
  logic       clr;
  logic [1:0] phase;
  logic       phase_valid;
  logic       err_conflict, err_encoding, err_transition, err_timing;
  logic [3:0] err_sticky;
  logic [7:0] rotations;

  typedef struct packed {
    logic [1:0] ph;
    logic       pv;
    logic [3:0] pulse;  // {timing, transition, encoding, conflict}
    logic [3:0] stk;
    logic [7:0] rot;
  } obs_t;

  obs_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [3:0]  stk_x;
  logic [7:0]  rot_x;

  traffic_light_monitor #(.GREEN_CYC(8), .YELLOW_CYC(3), .CNT_W(6)) dut (
    .clk            (clk),
    .rst_a          (rst_a),
    .n_lights       (n_l),
    .s_lights       (s_l),
    .e_lights       (e_l),
    .w_lights       (w_l),
    .clr            (clr),
    .phase          (phase),
    .phase_valid    (phase_valid),
    .err_conflict   (err_conflict),
    .err_encoding   (err_encoding),
    .err_transition (err_transition),
    .err_timing     (err_timing),
    .err_sticky     (err_sticky),
    .rotations      (rotations)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic [1:0] ph, logic pv, logic [3:0] pulse,
                              logic [3:0] stk, logic [7:0] rot);
    obs_t r;
    r.ph = ph; r.pv = pv; r.pulse = pulse; r.stk = stk; r.rot = rot;
    return r;
  endfunction

  // All buses red except direction d (0=N..3=W) showing v.
  function automatic logic [11:0] lamps(int d, logic [2:0] v);
    logic [11:0] l;
    l = ALLRED;
    l[(3-d)*3 +: 3] = v;
    return l;
  endfunction

  task automatic check(string tag);
    obs_t o, e;
    o = {phase, phase_valid, err_timing, err_transition, err_encoding,
         err_conflict, err_sticky, rotations};
    n_checks++;
    if (sb.size() == 0) begin
      $error("FAIL %s: no expected entry queued, got %h", tag, o);
      return;
    end
    e = sb.pop_front();
    assert (o === e) n_pass++;
    else $error("FAIL %s: got ph=%0d pv=%0b pulse=%b stk=%b rot=%0d, expected ph=%0d pv=%0b pulse=%b stk=%b rot=%0d",
                tag, o.ph, o.pv, o.pulse, o.stk, o.rot, e.ph, e.pv, e.pulse, e.stk, e.rot);
  endtask

  task automatic step(logic [11:0] l, logic c, obs_t e, string tag);
    {n_l, s_l, e_l, w_l} = l;
    clr = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Clean phase of direction d; bump marks a completed rotation on the red.
  task automatic run_dir(int d, int ng, int ny, int nr, bit bump, string tag);
    for (int i = 0; i < ng; i++)
      step(lamps(d, G), 1'b0, mk(2'(d), 1'b1, 4'b0000, stk_x, rot_x), {tag, "_g"});
    for (int i = 0; i < ny; i++)
      step(lamps(d, Y), 1'b0, mk(2'(d), 1'b1, 4'b0000, stk_x, rot_x), {tag, "_y"});
    for (int i = 0; i < nr; i++) begin
      if (i == 0 && bump) rot_x = rot_x + 8'd1;
      step(ALLRED, 1'b0, mk(2'(d), 1'b0, 4'b0000, stk_x, rot_x), {tag, "_r"});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    {n_l, s_l, e_l, w_l} = ALLRED;
    clr   = 1'b0;
    stk_x = 4'b0000;
    rot_x = 8'd0;
    #1 rst_a = 1'b0;
    #1;
    sb.push_back(mk(2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0));
    check("reset_async");
    @(posedge clk); #1;
    sb.push_back(mk(2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0));
    check("reset_edge");
    #3 rst_a = 1'b1;

    // Legal rotation from reset
    step(ALLRED, 1'b0, mk(2'd0, 1'b0, 4'b0000, stk_x, rot_x), "idle");
    step(ALLRED, 1'b0, mk(2'd0, 1'b0, 4'b0000, stk_x, rot_x), "idle");
    run_dir(0, 8, 3, 1, 1'b0, "rot_n");
    run_dir(1, 8, 3, 1, 1'b0, "rot_s");
    run_dir(2, 8, 3, 1, 1'b0, "rot_e");
    run_dir(3, 8, 3, 1, 1'b1, "rot_w");

    // Conflict N+E; FSM back in IDLE so S (not N) is accepted next
    stk_x = 4'b0001;
    step({G, R, G, R}, 1'b0, mk(2'd3, 1'b0, 4'b0001, stk_x, rot_x), "conflict");
    step(ALLRED, 1'b0, mk(2'd3, 1'b0, 4'b0000, stk_x, rot_x), "conflict_after");
    run_dir(1, 8, 3, 1, 1'b0, "idle_s");

    // Encoding error, clr, clr racing a pulse
    stk_x = 4'b0011;
    step({R, 3'b011, R, R}, 1'b0, mk(2'd1, 1'b0, 4'b0010, stk_x, rot_x), "encoding");
    stk_x = 4'b0000;
    step(ALLRED, 1'b1, mk(2'd1, 1'b0, 4'b0000, stk_x, rot_x), "clr");
    stk_x = 4'b0010;
    step({R, 3'b011, R, R}, 1'b1, mk(2'd1, 1'b0, 4'b0010, stk_x, rot_x), "clr_vs_pulse");
    stk_x = 4'b0000;
    step(ALLRED, 1'b1, mk(2'd1, 1'b0, 4'b0000, stk_x, rot_x), "clr2");
    step(ALLRED, 1'b0, mk(2'd1, 1'b0, 4'b0000, stk_x, rot_x), "idle_after_clr");

    // N green held 10 cycles: one timing pulse at count 9, none at yellow
    for (int i = 1; i <= 10; i++) begin
      if (i == 9) stk_x = 4'b1000;
      step(lamps(0, G), 1'b0,
           mk(2'd0, 1'b1, (i == 9) ? 4'b1000 : 4'b0000, stk_x, rot_x), "n_overrun");
    end
    run_dir(0, 0, 3, 1, 1'b0, "n_overrun_tail");
    stk_x = 4'b0000;
    step(ALLRED, 1'b1, mk(2'd0, 1'b0, 4'b0000, stk_x, rot_x), "clr3");

    // After N's all-red, E goes green: transition error, resync on E
    stk_x = 4'b0100;
    step(lamps(2, G), 1'b0, mk(2'd2, 1'b1, 4'b0100, stk_x, rot_x), "bad_order");
    run_dir(2, 5, 3, 1, 1'b0, "e_resync");
    run_dir(3, 8, 3, 1, 1'b0, "w_after_e");

    // Short N green (7 cycles): timing pulse on the yellow step
    run_dir(0, 7, 0, 0, 1'b0, "n_short");
    stk_x = 4'b1100;
    step(lamps(0, Y), 1'b0, mk(2'd0, 1'b1, 4'b1000, stk_x, rot_x), "n_short_exit");
    run_dir(0, 0, 2, 1, 1'b0, "n_short_tail");

    // Reset during S yellow, then a fresh W green is accepted
    run_dir(1, 8, 1, 0, 1'b0, "s_pre_reset");
    {n_l, s_l, e_l, w_l} = lamps(1, Y);
    #2 rst_a = 1'b0;
    #1;
    stk_x = 4'b0000;
    rot_x = 8'd0;
    sb.push_back(mk(2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0));
    check("reset_mid_phase");
    @(posedge clk); #1;
    sb.push_back(mk(2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0));
    check("reset_mid_held");
    #3 rst_a = 1'b1;
    step(lamps(1, Y), 1'b0, mk(2'd1, 1'b1, 4'b0000, stk_x, rot_x), "post_reset_s_yel");
    run_dir(3, 8, 3, 1, 1'b0, "w_fresh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter GREEN_CYC, default 8, required green dwell in clk cycles.
REQ-002 SHALL have parameter YELLOW_CYC, default 3, required yellow dwell in clk cycles.
REQ-003 SHALL have parameter CNT_W, default 6, dwell-counter width; must hold GREEN_CYC+1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_a  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports n_lights, s_lights, e_lights, w_lights  input  3 each  observed lamp buses; 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-007 SHALL have port clr  input  1  synchronous clear of sticky error flags.
REQ-008 SHALL have port phase  output  2  active direction: 0=N, 1=S, 2=E, 3=W.
REQ-009 SHALL have port phase_valid  output  1  exactly one direction non-red and legal.
REQ-010 SHALL have ports err_conflict, err_encoding, err_transition, err_timing  output  1 each  single-cycle error pulses.
REQ-011 SHALL have port err_sticky  output  4  latched OR of the four pulses, same bit order.
REQ-012 SHALL have port rotations  output  8  count of completed N->S->E->W cycles, wraps 255->0.

Function
REQ-013 SHALL register all inputs once; every output reflects the sample taken one edge earlier (latency 1 cycle).
REQ-014 SHALL pulse err_encoding when any bus is not one-hot.
REQ-015 SHALL pulse err_conflict when more than one bus is non-red; both pulses may fire in the same cycle.
REQ-016 SHALL run FSM IDLE, GREEN, YELLOW, ALLRED; IDLE is entered at reset.
REQ-017 IDLE: all-red holds; the first single green enters GREEN and sets the expected direction to that bus.
REQ-018 GREEN->YELLOW when the active bus goes yellow; YELLOW->ALLRED when it goes red.
REQ-019 ALLRED->GREEN only when the next direction in N->S->E->W order goes green; any other direction pulses err_transition.
REQ-020 Illegal per-bus steps (G->R, R->Y, Y->G) SHALL pulse err_transition.
REQ-021 On err_conflict, err_encoding or err_transition, the FSM SHALL return to IDLE and resynchronise, without a second error for the same event.
REQ-022 Dwell counter SHALL reset to 1 on each state entry, increment per cycle, and saturate at 2^CNT_W-1.
REQ-023 A green exit with count != GREEN_CYC, or a yellow exit with count != YELLOW_CYC, SHALL pulse err_timing.
REQ-024 A dwell exceeding its limit SHALL pulse err_timing once, when count reaches limit+1; no further pulse on exit.
REQ-025 rotations SHALL increment when W's yellow->red completes with no error since N's green began.
REQ-026 err_sticky bits SHALL set on their pulse; clr clears them, and a pulse in the same cycle as clr wins.

Reset
REQ-027 While rst_a=0: phase=0, phase_valid=0, all err pulses=0, err_sticky=0, rotations=0, FSM=IDLE, counters=0.
REQ-028 Reset asserted mid-phase SHALL abort immediately; after release the monitor SHALL need a fresh first green, with no error for the interrupted phase.

Structure
REQ-029 Package tlc_pkg SHALL hold the lamp encodings, the direction enum (N,S,E,W), the FSM state enum and the rotation-order function.
REQ-030 Sub-module tlc_dwell_cnt SHALL implement the saturating dwell counter with limit compare; the rest stays in one module.

Verification
REQ-031 Legal rotation N,S,E,W, each 8G/3Y/1 all-red -> no error pulses; rotations=1 after W's red; phase tracks 0,1,2,3.
REQ-032 n_lights=3'b001 and e_lights=3'b001 in the same cycle -> err_conflict=1 one cycle later; err_sticky=4'b0001; FSM returns to IDLE.
REQ-033 s_lights=3'b011 -> err_encoding pulse; err_sticky[1]=1; cleared by clr=1 for one cycle.
REQ-034 N green held 10 cycles -> err_timing pulses exactly once, at count 9; no pulse at yellow.
REQ-035 After N's all-red, E goes green -> err_transition pulse; monitor resyncs with E as expected direction.
REQ-036 rst_a=0 during S yellow -> all outputs 0 at once; after release, a W green is accepted without error.
